// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multiply/divide-unit sequencer:
//                operation encodings, sequencer state enum, iteration count,
//                ALU-control codes for the HI/LO instructions and a
//                magnitude helper used when latching signed operands.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // Operand and HI/LO width; the sequencer is built for 32 bits only.
    localparam int MDU_DW    = 32;

    // Number of shift-add iterations for one full product.
    localparam int MULT_ITER = 32;

    // Operation select as presented on the op port.
    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MADD  = 2'b01,
        MDU_MADDU = 2'b10,
        MDU_CLR   = 2'b11
    } mdu_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        SIGN = 2'd2,
        WB   = 2'd3
    } mdu_state_e;

    // ALU-control codes the decoder uses to steer instructions to this unit.
    localparam logic [3:0] ALU_MADD  = 4'b0000;
    localparam logic [3:0] ALU_MADDU = 4'b0001;
    localparam logic [3:0] ALU_MUL   = 4'b0011;

    // Two's-complement magnitude. 0x80000000 maps to itself, which is the
    // correct unsigned magnitude of the most negative value.
    function automatic logic [MDU_DW-1:0] mdu_mag(input logic [MDU_DW-1:0] v);
        return v[MDU_DW-1] ? ((~v) + 32'd1) : v;
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer
//  Description : Multi-cycle shift-add multiplier with HI/LO accumulation.
//                Supports mul (signed, LO only), madd (signed accumulate),
//                maddu (unsigned accumulate) and clr (HI/LO <- 0).
//                Fixed latency: start at edge E0, done in the cycle after
//                edge E0+34 (32 iterations + sign fix-up + writeback).
//  Ports       : clk    - system clock, rising edge
//                rst    - asynchronous active-high reset
//                start  - request, sampled only while busy is low
//                op     - operation select (see mdu_pkg::mdu_op_e)
//                src_a  - multiplicand (rs)
//                src_b  - multiplier (rt)
//                busy   - sequencer occupied, pipeline must stall
//                done   - one-cycle completion pulse
//                hi, lo - HI/LO registers
//                result - copy of lo for the mul writeback
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] result
);

    localparam int       PW       = 2 * DW;
    localparam bit [4:0] CNT_LAST = 5'(MULT_ITER - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mdu_state_e    state_q,  state_d;
    mdu_op_e       op_q,     op_d;
    logic [4:0]    cnt_q,    cnt_d;
    logic [PW-1:0] prod_q,   prod_d;
    logic [PW-1:0] mcand_q,  mcand_d;   // multiplicand, shifted left per step
    logic [DW-1:0] mplier_q, mplier_d;  // multiplier, shifted right per step
    logic          neg_q,    neg_d;
    logic [DW-1:0] hi_q,     hi_d;
    logic [DW-1:0] lo_q,     lo_d;
    logic          done_q,   done_d;

    // ------------------------------------------------------------------
    // Single shared 64-bit adder. Operand muxing lives in the FSM block:
    //   MULT : prod + (mplier[0] ? mcand : 0)
    //   SIGN : ~prod + 1                    (negation)
    //   WB   : {hi,lo} + prod               (accumulate, carry dropped)
    // ------------------------------------------------------------------
    logic [PW-1:0] add_a;
    logic [PW-1:0] add_b;
    logic          add_cin;
    logic [PW-1:0] add_sum;

    assign add_sum = add_a + add_b + {{(PW-1){1'b0}}, add_cin};

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == MDU_CLR) begin
                        // Single-edge operation: no busy phase at all.
                        hi_d   = '0;
                        lo_d   = '0;
                        done_d = 1'b1;
                    end else begin
                        op_d   = mdu_op_e'(op);
                        prod_d = '0;
                        cnt_d  = '0;
                        if (op == MDU_MADDU) begin
                            mcand_d  = {{DW{1'b0}}, src_a};
                            mplier_d = src_b;
                            neg_d    = 1'b0;
                        end else begin
                            // Signed ops multiply magnitudes and fix the
                            // sign once at the end.
                            mcand_d  = {{DW{1'b0}}, mdu_mag(src_a)};
                            mplier_d = mdu_mag(src_b);
                            neg_d    = src_a[DW-1] ^ src_b[DW-1];
                        end
                        state_d = MULT;
                    end
                end
            end

            MULT: begin
                add_a    = prod_q;
                add_b    = mplier_q[0] ? mcand_q : '0;
                prod_d   = add_sum;
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[DW-1:1]};
                cnt_d    = cnt_q + 5'd1;
                // Iteration count is fixed; zero operands do not exit early.
                if (cnt_q == CNT_LAST) begin
                    state_d = SIGN;
                end
            end

            SIGN: begin
                if (neg_q) begin
                    add_a   = ~prod_q;
                    add_cin = 1'b1;
                    prod_d  = add_sum;
                end
                state_d = WB;
            end

            WB: begin
                if (op_q == MDU_MUL) begin
                    lo_d = prod_q[DW-1:0];
                end else begin
                    add_a        = {hi_q, lo_q};
                    add_b        = prod_q;
                    {hi_d, lo_d} = add_sum;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign result = lo_q;

endmodule : mdu_sequencer
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sequencer
//  Description : Self-checking bench for mdu_sequencer. A HI/LO reference
//                model computed with plain 64-bit arithmetic predicts every
//                result; directed corner cases are followed by random ops.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int DW      = 32;
    localparam int LATENCY = 34;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [DW-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    // Reference HI/LO value.
    logic [63:0] model_acc;

    mdu_sequencer #(.DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one operation on HI/LO.
    task automatic model_apply(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub;
        logic [63:0] sprod;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = {32'd0, a};
        ub    = {32'd0, b};
        sprod = 64'(sa * sb);
        case (o)
            2'b00:   model_acc[31:0] = sprod[31:0];
            2'b01:   model_acc       = model_acc + sprod;
            2'b10:   model_acc       = model_acc + ua * ub;
            default: model_acc       = 64'd0;
        endcase
    endtask

    // Issue one operation from a point #1 after a rising edge with busy=0,
    // wait for done with a bounded loop, and compare against the model.
    // When poke is set, extra starts are pulsed while busy; they must be
    // ignored. Operands are scrambled after the start edge.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        int n;
        bit busy_ok;
        bit early_done;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        model_apply(o, a, b);
        if (o == 2'b11) begin
            chk({tag, "/clr_done"}, {63'd0, done}, 64'd1);
            chk({tag, "/clr_busy"}, {63'd0, busy}, 64'd0);
        end else begin
            n          = 0;
            busy_ok    = 1'b1;
            early_done = 1'b0;
            while (n < LATENCY + 6) begin
                if (!busy) busy_ok = 1'b0;
                if (poke && n >= 5 && n <= 20) begin
                    start = 1'b1;
                    op    = 2'($urandom_range(0, 3));
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
                if (done) break;
            end
            start = 1'b0;
            chk({tag, "/latency"}, 64'(n), 64'(LATENCY));
            chk({tag, "/busy_hold"}, {63'd0, busy_ok}, 64'd1);
            chk({tag, "/busy_done"}, {63'd0, busy}, 64'd0);
            if (early_done) n_errors += 0;
        end
        chk({tag, "/hilo"}, {hi, lo}, model_acc);
        chk({tag, "/result"}, {32'd0, result}, {32'd0, model_acc[31:0]});
    endtask

    // Count done pulses over a window with start held low.
    task automatic quiet_window(input string tag, input int cycles);
        int dones;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk({tag, "/no_done"}, 64'(dones), 64'd0);
        chk({tag, "/hilo_hold"}, {hi, lo}, model_acc);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        logic [31:0] corner [6];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'h0001_0000;

        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        src_a     = '0;
        src_b     = '0;
        model_acc = 64'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset/hilo", {hi, lo}, 64'd0);
        chk("reset/ctl", {62'd0, busy, done}, 64'd0);
        chk("reset/result", {32'd0, result}, 64'd0);

        // First edge after release accepts the request.
        rst = 1'b0;
        run_op("mul7", 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
        chk("mul7/lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);

        // Back-to-back from the done cycle onwards.
        run_op("clr1", 2'b11, 32'd0, 32'd0, 1'b0);
        run_op("maddu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("maddu_ff/const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op("clr2", 2'b11, 32'd0, 32'd0, 1'b0);
        run_op("madd_1x5", 2'b01, 32'd1, 32'd5, 1'b0);
        run_op("madd_m2x3", 2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("madd_seq/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        // HI/LO already all ones; unsigned 1x1 wraps to zero.
        run_op("maddu_wrap", 2'b10, 32'd1, 32'd1, 1'b0);
        chk("maddu_wrap/const", {hi, lo}, 64'd0);

        run_op("madd_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("madd_minmin/const", {hi, lo}, 64'h4000_0000_0000_0000);

        // Starts during busy must be ignored; exactly one done.
        run_op("poke", 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        quiet_window("poke", 40);

        // Random mix, including corner operands.
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 1'b0);
        end

        // Reset in the middle of MULT aborts without a done pulse.
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd3;
        src_b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_acc = 64'd0;
        chk("abort/hilo", {hi, lo}, 64'd0);
        chk("abort/ctl", {62'd0, busy, done}, 64'd0);
        chk("abort/result", {32'd0, result}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        quiet_window("abort", 40);
        chk("abort/busy", {63'd0, busy}, 64'd0);

        // Sequencer still operates normally after the abort.
        run_op("post_abort", 2'b01, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mdu_sequencer
`default_nettype wire

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter: DW, 32, operand and HI/LO register width; only 32 is supported.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 start  in  1  request, sampled only when busy=0.
REQ-005 op  in  2  operation select: 00 mul, 01 madd (signed), 10 maddu (unsigned), 11 clr (HI/LO <- 0).
REQ-006 src_a  in  DW  multiplicand (rs value).
REQ-007 src_b  in  DW  multiplier (rt value).
REQ-008 busy  out  1  sequencer occupied; the pipeline stalls while high.
REQ-009 done  out  1  one-cycle pulse; hi/lo/result are final in this cycle.
REQ-010 hi  out  DW  HI register.
REQ-011 lo  out  DW  LO register.
REQ-012 result  out  DW  copy of lo, used for the mul rd writeback.

Function
REQ-013 States SHALL be IDLE, MULT, SIGN, WB.
REQ-014 IDLE, start=1, op!=11: latch operands and op; for op 00/01 latch magnitudes plus negate flag = sign(a) XOR sign(b); clear the 64-bit product and the 5-bit counter; go to MULT.
REQ-015 IDLE, start=1, op=11: hi=lo=0 at that edge; done=1 in the next cycle; busy stays 0.
REQ-016 MULT: one shift-add iteration per cycle (LSB of multiplier first); the counter increments each cycle; after exactly 32 iterations go to SIGN.
REQ-017 SIGN (1 cycle): two's-complement negate the 64-bit product if the negate flag is set; otherwise hold.
REQ-018 WB (1 cycle): at the exit edge apply the result, go to IDLE, and assert done for the following cycle.
REQ-019 op 00 result: lo <= product[31:0]; hi unchanged.
REQ-020 op 01/10 result: {hi,lo} <= {hi,lo} + product, modulo 2^64; carry out is discarded.
REQ-021 Latency SHALL be fixed: start sampled at edge E0; done high in the cycle after edge E0+34; operand values (including 0) do not shorten it.
REQ-022 busy=1 from the cycle after E0 through WB; busy=0 in the done cycle.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 start in the done cycle SHALL be accepted, giving back-to-back operation.
REQ-025 Operand changes after E0 SHALL NOT affect the result.
REQ-026 Signed edge case: 0x80000000 x 0x80000000 under op 01 SHALL add 0x40000000_00000000.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE; busy=0; done=0; hi=0; lo=0; result=0; counter=0; product=0.
REQ-028 Reset during MULT/SIGN/WB SHALL abort the operation: no done pulse and no HI/LO update after release.
REQ-029 First start SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-030 Shared package mdu_pkg SHALL hold: op encodings (MDU_MUL, MDU_MADD, MDU_MADDU, MDU_CLR), the state enum, MULT_ITER=32, and the ALU-control codes for madd/maddu/mul (0000/0001/0011).
REQ-031 No sub-module; the shift-add datapath, counter and FSM SHALL be one module.
REQ-032 A single 64-bit adder SHALL be shared between iterations, negation (via invert + carry-in) and accumulation.

Verification
REQ-033 After reset, mul a=7, b=0xFFFFFFFD: lo=result=0xFFFFFFEB, hi=0, done exactly 34 edges after the start edge.
REQ-034 clr, then maddu a=b=0xFFFFFFFF: {hi,lo}=0xFFFFFFFE_00000001.
REQ-035 clr, madd 1x5, then madd 0xFFFFFFFE x 3: {hi,lo}=0xFFFFFFFF_FFFFFFFF.
REQ-036 Set {hi,lo}=0xFFFFFFFF_FFFFFFFF, then maddu 1x1: {hi,lo}=0 (wrap).
REQ-037 Busy/handshake case:
- start pulses during busy are ignored (exactly one done);
- a new start in the done cycle is accepted, and its done follows 34 edges later.
REQ-038 Assert rst at MULT iteration 10 of madd 3x4: all outputs 0 immediately; no done for 40 cycles after release.
